// File: rtl/store_narrow_serializer.sv
// Store-path narrowing unit: truncates a 32-bit store to byte/half/word
// and emits it little-endian as single-byte writes on the memory port.
module store_narrow_serializer #(
  parameter int ADDR_W      = 32,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        last_q, last_d;

  logic        bad_req;
  logic [31:0] trunc_data;
  logic [1:0]  req_last;

  // Request legality and width-truncated data
  always_comb begin
    bad_req    = 1'b0;
    trunc_data = 32'h0;
    req_last   = 2'd0;
    unique case (req_size)
      2'b00: begin
        trunc_data = {24'h0, req_data[7:0]};
        req_last   = 2'd0;
      end
      2'b01: begin
        trunc_data = {16'h0, req_data[15:0]};
        req_last   = 2'd1;
        bad_req    = ALIGN_CHECK && req_addr[0];
      end
      2'b10: begin
        trunc_data = req_data;
        req_last   = 2'd3;
        bad_req    = ALIGN_CHECK &&
                     (req_addr[1:0] != 2'b00);
      end
      default: bad_req = 1'b1;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 32'h0;
      base_q  <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic and outputs
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    base_d    = base_q;
    idx_d     = idx_q;
    last_d    = last_q;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (bad_req) begin
            state_d = S_ERR;
          end else begin
            state_d = S_WRITE;
            data_d  = trunc_data;
            base_d  = req_addr;
            idx_d   = 2'd0;
            last_d  = req_last;
          end
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + ADDR_W'(idx_q);
        mem_wdata = data_q[{idx_q, 3'b000} +: 8];
        if (mem_ready) begin
          if (idx_q == last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_narrow_serializer.sv
// Bench for store_narrow_serializer: table vectors, hand-written
// corner sequences and randomized requests against a byte-list model.
module tb_store_narrow_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        mem_ready = 1'b0;
  int          s = 0;

  logic [1:0]  valid_v;
  logic [1:0]  ready_v, we_v, busy_v, done_v, err_v;
  logic [31:0] addr_v [2];
  logic [7:0]  wd_v [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] got_a[$];
  logic [7:0]  got_d[$];
  logic [31:0] pres_a[$];
  logic [7:0]  pres_d[$];

  always #5 clk = ~clk;

  assign valid_v[0] = req_valid && (s == 0);
  assign valid_v[1] = req_valid && (s == 1);

  store_narrow_serializer #(
    .ADDR_W(32), .ALIGN_CHECK(1'b1)
  ) u_chk (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid_v[0]), .req_ready(ready_v[0]),
    .req_size(req_size), .req_addr(req_addr),
    .req_data(req_data),
    .mem_we(we_v[0]), .mem_addr(addr_v[0]),
    .mem_wdata(wd_v[0]), .mem_ready(mem_ready),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0])
  );

  store_narrow_serializer #(
    .ADDR_W(32), .ALIGN_CHECK(1'b0)
  ) u_nochk (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid_v[1]), .req_ready(ready_v[1]),
    .req_size(req_size), .req_addr(req_addr),
    .req_data(req_data),
    .mem_we(we_v[1]), .mem_addr(addr_v[1]),
    .mem_wdata(wd_v[1]), .mem_ready(mem_ready),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1])
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // One request; the model is the list of (addr,byte) writes the
  // request must produce, or an error with no writes.
  task automatic run_txn(input bit ac,
                         input logic [1:0] sz,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input int stall_pct,
                         input int force_stall);
    logic [31:0] ea[$];
    logic [7:0]  ed[$];
    bit   e_err, fin, prev_stall;
    int   n, dcyc, ecyc, ndone, nerr, stalls;
    logic [31:0] pa;
    logic [7:0]  pd;
    got_a.delete(); got_d.delete();
    pres_a.delete(); pres_d.delete();
    s = ac ? 0 : 1;
    e_err = (sz == 2'b11) ||
            (ac && ((sz == 2'b01 && a[0]) ||
                    (sz == 2'b10 && a[1:0] != 2'b00)));
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (!e_err)
      for (int i = 0; i < n; i++) begin
        ea.push_back(a + 32'(i));
        ed.push_back(8'(d >> (8 * i)));
      end
    @(negedge clk);
    chk("ready_idle", ready_v[s], 1);
    req_valid = 1'b1;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    mem_ready = 1'b1;
    dcyc = -1; ecyc = -1;
    ndone = 0; nerr = 0; stalls = 0;
    fin = 1'b0; prev_stall = 1'b0;
    pa = '0; pd = '0;
    for (int c = 1; c <= 60 && !fin; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_data  = $urandom;
      chk("busy", busy_v[s], 1);
      if (done_v[s]) begin
        ndone++; dcyc = c; fin = 1'b1;
        chk("we_in_done", we_v[s], 0);
      end
      if (err_v[s]) begin
        nerr++; ecyc = c; fin = 1'b1;
        chk("we_in_err", we_v[s], 0);
        chk("done_in_err", done_v[s], 0);
      end
      if (we_v[s]) begin
        if (prev_stall) begin
          chk("hold_addr", addr_v[s], pa);
          chk("hold_data", wd_v[s], pd);
        end
        if (stalls < force_stall) begin
          mem_ready = 1'b0;
          stalls++;
        end else begin
          mem_ready = ($urandom_range(99) < stall_pct)
                      ? 1'b0 : 1'b1;
        end
        pres_a.push_back(addr_v[s]);
        pres_d.push_back(wd_v[s]);
        if (mem_ready) begin
          got_a.push_back(addr_v[s]);
          got_d.push_back(wd_v[s]);
        end
        prev_stall = !mem_ready;
        pa = addr_v[s];
        pd = wd_v[s];
      end else begin
        mem_ready  = 1'($urandom_range(1));
        prev_stall = 1'b0;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("post_idle",
        {ready_v[s], busy_v[s], done_v[s], err_v[s]},
        4'b1000);
    chk("err_cnt", nerr, e_err ? 1 : 0);
    chk("done_cnt", ndone, e_err ? 0 : 1);
    chk("nwrites", got_a.size(), ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (i < got_a.size()) begin
        chk("wr_addr", got_a[i], ea[i]);
        chk("wr_data", got_d[i], ed[i]);
      end
    if (e_err)
      chk("err_cyc", ecyc, 1);
    else if (stall_pct == 0 && force_stall == 0)
      chk("done_cyc", dcyc, n + 1);
  endtask

  typedef struct {
    bit          ac;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    bit          exp_err;
    int          exp_n;
    logic [31:0] exp_la;
    logic [7:0]  exp_ld;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1, 2'b10, 32'h100, 32'hA1B2C3D4,
              0, 4, 32'h103, 8'hA1};
    vt[1] = '{1, 2'b01, 32'h202, 32'hFFFF1234,
              0, 2, 32'h203, 8'h12};
    vt[2] = '{1, 2'b00, 32'h7, 32'hAAAAAA55,
              0, 1, 32'h7, 8'h55};
    vt[3] = '{1, 2'b11, 32'h0, 32'h12345678,
              1, 0, 32'h0, 8'h0};
    vt[4] = '{1, 2'b10, 32'h102, 32'h12345678,
              1, 0, 32'h0, 8'h0};
    vt[5] = '{1, 2'b01, 32'h201, 32'h12345678,
              1, 0, 32'h0, 8'h0};
    vt[6] = '{0, 2'b10, 32'hFFFFFFFE, 32'h11223344,
              0, 4, 32'h1, 8'h11};
    vt[7] = '{0, 2'b01, 32'h201, 32'h9999ABCD,
              0, 2, 32'h202, 8'hAB};

    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ctrl",
          {ready_v[k], we_v[k], busy_v[k],
           done_v[k], err_v[k]}, 5'b10000);
      chk("rst_addr", addr_v[k], 0);
      chk("rst_wdata", wd_v[k], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vt[i].ac, vt[i].sz, vt[i].a, vt[i].d, 0, 0);
      chk("vec_n", got_a.size(), vt[i].exp_n);
      if (vt[i].exp_n > 0 && got_a.size() > 0) begin
        chk("vec_last_a", got_a[got_a.size()-1],
            vt[i].exp_la);
        chk("vec_last_d", got_d[got_d.size()-1],
            vt[i].exp_ld);
      end
    end

    // Halfword with two stall cycles on the first byte
    run_txn(1, 2'b01, 32'h202, 32'hFFFF1234, 0, 2);
    chk("stall_pres", pres_a.size(), 4);
    if (pres_a.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("stall_a", pres_a[i], 32'h202);
        chk("stall_d", pres_d[i], 8'h34);
      end
      chk("stall_a3", pres_a[3], 32'h203);
      chk("stall_d3", pres_d[3], 8'h12);
    end

    // Byte store, then a second request held on req_valid
    s = 0;
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b00;
    req_addr = 32'h7; req_data = 32'hAAAAAA55;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("b2b_c1", {we_v[0], ready_v[0]}, 2'b10);
    chk("b2b_c1_a", addr_v[0], 32'h7);
    chk("b2b_c1_d", wd_v[0], 8'h55);
    req_size = 2'b10; req_addr = 32'h300;
    req_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("b2b_c2",
        {done_v[0], we_v[0], ready_v[0]}, 3'b100);
    @(negedge clk);
    chk("b2b_c3", {ready_v[0], busy_v[0]}, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_c4", {we_v[0], busy_v[0]}, 2'b11);
    chk("b2b_c4_a", addr_v[0], 32'h300);
    chk("b2b_c4_d", wd_v[0], 8'h0D);
    begin
      int k;
      k = 0;
      while (!done_v[0] && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_done", k, 4);
    end
    @(negedge clk);
    chk("b2b_idle", ready_v[0], 1);

    // Reset in the middle of a word store
    @(negedge clk);
    req_valid = 1'b1; req_size = 2'b10;
    req_addr = 32'h400; req_data = 32'h01020304;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_a0", addr_v[0], 32'h400);
    @(negedge clk);
    chk("rw_a1", addr_v[0], 32'h401);
    @(negedge clk);
    chk("rw_a2", addr_v[0], 32'h402);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_rst_ctrl",
        {ready_v[0], we_v[0], busy_v[0],
         done_v[0], err_v[0]}, 5'b10000);
    chk("rw_rst_addr", addr_v[0], 0);
    chk("rw_rst_wd", wd_v[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int nwe;
      nwe = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (we_v[0]) nwe++;
      end
      chk("rw_no_we", nwe, 0);
      chk("rw_idle", {ready_v[0], busy_v[0]}, 2'b10);
    end

    // Randomized requests
    for (int t = 0; t < 60; t++) begin
      bit          ac;
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      ac = 1'($urandom_range(1));
      r  = $urandom_range(9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 :
           (r < 9) ? 2'b10 : 2'b11;
      a  = $urandom;
      if ($urandom_range(3) == 0)
        a = 32'hFFFFFFFC + 32'($urandom_range(3));
      if (ac && $urandom_range(1) == 1)
        a = a & 32'hFFFFFFFC;
      run_txn(ac, sz, a, $urandom,
              ($urandom_range(1) == 1) ? 30 : 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
